// File: rtl/dmem_controller_pkg.sv
// Shared types for the data-memory controller and its load/store alignment logic.
package dmem_controller_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } memFunc3_t;

    // Stores share encodings with the signed loads.
    localparam memFunc3_t SB = LB;
    localparam memFunc3_t SH = LH;
    localparam memFunc3_t SW = LW;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmemState_t;

    localparam int unsigned CNT_WIDTH = 4;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane selection, load extension and store write-mask generation for one 32-bit word.
module load_store_align
    import dmem_controller_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic        isStore,
    input  logic [1:0]  byteOff,
    input  logic [31:0] storeData,
    input  logic [31:0] memWord,
    output logic [31:0] writeWord,
    output logic [3:0]  writeMask,
    output logic [31:0] loadData,
    output logic        accessErr
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic        badWidth;
    logic        badAlign;

    assign laneByte = memWord[{byteOff, 3'b000} +: 8];
    assign laneHalf = memWord[{byteOff[1], 4'b0000} +: 16];

    // Store data is replicated across lanes; the mask picks which lanes land.
    always_comb begin
        badWidth  = 1'b0;
        badAlign  = 1'b0;
        loadData  = '0;
        writeMask = '0;
        writeWord = '0;
        case (memFunc3_t'(func3))
            LB: begin
                loadData  = {{24{laneByte[7]}}, laneByte};
                writeMask = 4'b0001 << byteOff;
                writeWord = {4{storeData[7:0]}};
            end
            LH: begin
                badAlign  = byteOff[0];
                loadData  = {{16{laneHalf[15]}}, laneHalf};
                writeMask = 4'b0011 << {byteOff[1], 1'b0};
                writeWord = {2{storeData[15:0]}};
            end
            LW: begin
                badAlign  = (byteOff != 2'b00);
                loadData  = memWord;
                writeMask = 4'b1111;
                writeWord = storeData;
            end
            LBU: begin
                badWidth = isStore;
                loadData = {24'h0, laneByte};
            end
            LHU: begin
                badWidth = isStore;
                badAlign = byteOff[0];
                loadData = {16'h0, laneHalf};
            end
            default: badWidth = 1'b1;
        endcase
        accessErr = badWidth | badAlign;
        if (accessErr) begin
            writeMask = '0;
            loadData  = '0;
        end
    end

endmodule

// File: rtl/dmem_controller.sv
// Multi-cycle data-memory controller: IDLE/BUSY/DONE handshake in front of a byte-writable
// word array, with sign/zero-extended loads and misalignment reporting.
module dmem_controller
    import dmem_controller_pkg::*;
#(
    parameter int unsigned DM_MEM_DEPTH = 4096,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FUNC3_WIDTH  = 3,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic [FUNC3_WIDTH-1:0] func3,
    input  logic [DATA_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   ready,
    output logic                   misalign
);

    localparam int unsigned IDX_WIDTH = (DM_MEM_DEPTH > 1) ? $clog2(DM_MEM_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    dmemState_t           state;
    logic [CNT_WIDTH-1:0] count;
    logic                 pendStore;
    logic [31:0]          mem [DM_MEM_DEPTH];

    logic                 request;
    logic                 accessNow;
    logic                 storeNow;
    logic                 f3High;
    logic                 alignErr;
    logic                 accessErr;
    logic                 memWe;
    logic [IDX_WIDTH-1:0] wordIdx;
    logic [31:0]          memWord;
    logic [31:0]          writeWord;
    logic [31:0]          loadData;
    logic [3:0]           writeMask;

    assign request   = memRead | memWrite;
    assign accessNow = (state == BUSY) && (count == '0);
    // A request dropped mid-BUSY still completes using the kind latched at acceptance.
    assign storeNow  = request ? memWrite : pendStore;
    assign wordIdx   = IDX_WIDTH'((addr >> 2) % DATA_WIDTH'(DM_MEM_DEPTH));
    assign memWord   = mem[wordIdx];
    assign accessErr = alignErr | f3High;
    assign memWe     = accessNow & storeNow & ~accessErr;
    assign ready     = (state == DONE) || ((state == IDLE) && !request);

    if (FUNC3_WIDTH > 3) begin : gF3High
        assign f3High = |func3[FUNC3_WIDTH-1:3];
    end else begin : gF3Narrow
        assign f3High = 1'b0;
    end

    load_store_align uAlign (
        .func3     (func3[2:0]),
        .isStore   (storeNow),
        .byteOff   (addr[1:0]),
        .storeData (wdata[31:0]),
        .memWord   (memWord),
        .writeWord (writeWord),
        .writeMask (writeMask),
        .loadData  (loadData),
        .accessErr (alignErr)
    );

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (writeMask[b]) begin
                    mem[wordIdx][8*b +: 8] <= writeWord[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            pendStore <= 1'b0;
            rdata     <= '0;
            misalign  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (request) begin
                        state     <= BUSY;
                        count     <= CNT_LOAD;
                        pendStore <= memWrite;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state    <= DONE;
                        misalign <= accessErr;
                        if (!storeNow) begin
                            rdata <= f3High ? '0 : DATA_WIDTH'(loadData);
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller: handshake latency, load/store lanes, errors, reset, wrap.
module tb_dmem_controller;

    localparam int unsigned DEPTH = 4096;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_BAD = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_controller #(
        .DM_MEM_DEPTH (DEPTH),
        .DATA_WIDTH   (32),
        .FUNC3_WIDTH  (3),
        .LATENCY      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memRead  (memRead),
        .memWrite (memWrite),
        .func3    (func3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .misalign (misalign)
    );

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        memRead  = rd;
        memWrite = wr;
        func3    = f3;
        addr     = a;
        wdata    = d;
    endtask

    // Cycles from the current cycle (cycle 0) until ready is seen; -1 if it never comes.
    task automatic waitReady(output int n);
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
        end
        if (!ready) n = -1;
    endtask

    // Called at posedge+1 with the controller idle; returns at posedge+1 with it idle again.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rdOut, output logic misOut);
        drive(rd, wr, f3, a, d);
        waitReady(lat);
        rdOut  = rdata;
        misOut = misalign;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        checks++;
        if (misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset_misalign: got %b expected 0", misalign);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word;
        int lat;
        logic [31:0] rd;
        logic mis;
        access(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rd, mis);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL sw_latency: got %0d expected 3", lat);
        end
        checks++;
        if (mis !== 1'b0) begin
            failures++;
            $display("FAIL sw_misalign: got %b expected 0", mis);
        end
        access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, lat, rd, mis);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL lw_latency: got %0d expected 3", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte;
        int lat;
        logic [31:0] rd;
        logic mis;
        access(1'b0, 1'b1, F3_W, 32'h10, 32'h0, lat, rd, mis);
        access(1'b0, 1'b1, F3_B, 32'h11, 32'h000000A5, lat, rd, mis);
        access(1'b1, 1'b0, F3_B, 32'h11, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'hFFFFFFA5) begin
            failures++;
            $display("FAIL lb_sext: got %h expected ffffffa5", rd);
        end
        access(1'b1, 1'b0, F3_BU, 32'h11, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h000000A5) begin
            failures++;
            $display("FAIL lbu_zext: got %h expected 000000a5", rd);
        end
        access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h0000A500) begin
            failures++;
            $display("FAIL sb_lane: got %h expected 0000a500", rd);
        end
    endtask

    task automatic test_half;
        int lat;
        logic [31:0] rd;
        logic mis;
        access(1'b0, 1'b1, F3_W, 32'h30, 32'h80017FFE, lat, rd, mis);
        access(1'b1, 1'b0, F3_H, 32'h30, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h00007FFE) begin
            failures++;
            $display("FAIL lh_low: got %h expected 00007ffe", rd);
        end
        access(1'b1, 1'b0, F3_H, 32'h32, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            failures++;
            $display("FAIL lh_high_sext: got %h expected ffff8001", rd);
        end
        access(1'b1, 1'b0, F3_HU, 32'h32, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h00008001) begin
            failures++;
            $display("FAIL lhu_zext: got %h expected 00008001", rd);
        end
        access(1'b0, 1'b1, F3_H, 32'h32, 32'hFFFF1234, lat, rd, mis);
        access(1'b1, 1'b0, F3_W, 32'h30, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h12347FFE) begin
            failures++;
            $display("FAIL sh_lanes: got %h expected 12347ffe", rd);
        end
    endtask

    task automatic test_misalign;
        int lat;
        logic [31:0] rd;
        logic mis;
        access(1'b1, 1'b0, F3_H, 32'h13, 32'h0, lat, rd, mis);
        checks++;
        if (mis !== 1'b1) begin
            failures++;
            $display("FAIL lh_misalign_flag: got %b expected 1", mis);
        end
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL lh_misalign_rdata: got %h expected 00000000", rd);
        end
        checks++;
        if (misalign !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse_width: got %b expected 0", misalign);
        end
        access(1'b0, 1'b1, F3_W, 32'h20, 32'hCAFEF00D, lat, rd, mis);
        access(1'b0, 1'b1, F3_W, 32'h22, 32'h12345678, lat, rd, mis);
        checks++;
        if (mis !== 1'b1 || lat !== 3) begin
            failures++;
            $display("FAIL sw_misalign: got mis=%b lat=%0d expected mis=1 lat=3", mis, lat);
        end
        access(1'b1, 1'b0, F3_W, 32'h20, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'hCAFEF00D || mis !== 1'b0) begin
            failures++;
            $display("FAIL sw_misalign_nowrite: got %h mis=%b expected cafef00d mis=0", rd, mis);
        end
        access(1'b1, 1'b0, F3_BAD, 32'h20, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h0 || mis !== 1'b1) begin
            failures++;
            $display("FAIL bad_func3: got %h mis=%b expected 00000000 mis=1", rd, mis);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        drive(1'b0, 1'b1, F3_W, 32'h0, 32'h13579BDF);
        waitReady(lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL b2b_first_latency: got %0d expected 3", lat);
        end
        // Follow-up load is already present during DONE.
        drive(1'b1, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        waitReady(lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL b2b_second_latency: got %0d expected 3", lat);
        end
        checks++;
        if (rdata !== 32'h13579BDF) begin
            failures++;
            $display("FAIL b2b_data: got %h expected 13579bdf", rdata);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_reset_busy;
        int lat;
        logic [31:0] rd;
        logic mis;
        access(1'b0, 1'b1, F3_W, 32'h40, 32'h11111111, lat, rd, mis);
        access(1'b1, 1'b0, F3_W, 32'h40, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h11111111) begin
            failures++;
            $display("FAIL rb_prior: got %h expected 11111111", rd);
        end
        drive(1'b0, 1'b1, F3_W, 32'h40, 32'h00000055);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL rb_ready: got %b expected 1", ready);
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL rb_rdata: got %h expected 00000000", rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, F3_W, 32'h40, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h11111111) begin
            failures++;
            $display("FAIL rb_nowrite: got %h expected 11111111", rd);
        end
    endtask

    task automatic test_wrap;
        int lat;
        logic [31:0] rd;
        logic mis;
        access(1'b0, 1'b1, F3_W, 32'(4 * DEPTH), 32'h00000077, lat, rd, mis);
        access(1'b1, 1'b0, F3_W, 32'h0, 32'h0, lat, rd, mis);
        checks++;
        if (rd !== 32'h00000077) begin
            failures++;
            $display("FAIL wrap: got %h expected 00000077", rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_back_to_back();
        test_reset_busy();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
